// File: rtl/seq_pkg.sv
// Shared types and encodings for the control sequencer.
// States, opcodes, ALU ops, GPR selects and the strobe bundle.
package seq_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_F0,
    ST_F1,
    ST_F2,
    ST_F3,
    ST_D,
    ST_E0,
    ST_E1,
    ST_E2,
    ST_L0,
    ST_L1,
    ST_L2,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_HALT,
    ST_WAIT_STEP
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_MOV = 4'h5;
  localparam logic [3:0] OP_LD  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [2:0] ALU_INC  = 3'b101;

  localparam logic [2:0] SEL_ZERO = 3'b000;
  localparam logic [2:0] SEL_PC   = 3'b001;
  localparam logic [2:0] SEL_RD1  = 3'b010;
  localparam logic [2:0] SEL_RD2  = 3'b011;
  localparam logic [2:0] SEL_RS1  = 3'b100;
  localparam logic [2:0] SEL_RS2  = 3'b101;

  typedef struct packed {
    logic       gpr_in;
    logic       gpr_out;
    logic [2:0] gpr_select;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       mem_read;
    logic       mem_write;
    logic       alu_a_in;
    logic       alu_b_in;
    logic       alu_out;
    logic [2:0] alu_op;
  } strobe_t;

  function automatic logic is_mem_state(state_t s);
    return (s == ST_F2) || (s == ST_L1) || (s == ST_S2);
  endfunction

endpackage

// File: rtl/seq_mem_wait.sv
// Memory handshake wait counter shared by F2, L1 and S2.
// Flags done on mem_ready, timeout when the limit is hit without it.
module seq_mem_wait
  import seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic mem_ready,
  output logic done,
  output logic timeout
);

  localparam int unsigned CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (busy && !mem_ready) begin
      cnt <= cnt + CW'(1);
    end
  end

  // ready on the limit cycle still wins over the timeout
  assign done    = busy && mem_ready;
  assign timeout = busy && !mem_ready && (cnt == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer driving the GPR file and bus strobes.
// Define SINGLE_STEP_EN to add the step input and WAIT_STEP gating.
module control_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned INSTR_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            DATA,
  input  logic                   mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic                   step,
`endif
  output logic                   GPR_in,
  output logic                   GPR_out,
  output logic [2:0]             GPR_select,
  output logic [2:0]             Rd_1,
  output logic [2:0]             Rd_2,
  output logic [2:0]             Rs_1,
  output logic [2:0]             Rs_2,
  output logic                   MAR_in,
  output logic                   MDR_in,
  output logic                   MDR_out,
  output logic                   MEM_read,
  output logic                   MEM_write,
  output logic                   ALU_A_in,
  output logic                   ALU_B_in,
  output logic                   ALU_out,
  output logic [2:0]             ALU_op,
  output logic                   halted,
  output logic                   fault,
  output logic [INSTR_CNT_W-1:0] instr_count
);

`ifdef SINGLE_STEP_EN
  localparam state_t RESUME = ST_WAIT_STEP;
`else
  localparam state_t RESUME = ST_F0;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic        busy;
  logic        start;
  logic        done;
  logic        timeout;
  logic        retire;
  strobe_t     stb;

  assign opcode = ir[15:12];
  assign Rd_1   = ir[11:9];
  assign Rs_1   = ir[8:6];
  assign Rs_2   = ir[5:3];
  assign Rd_2   = ir[2:0];

  assign busy  = is_mem_state(state);
  assign start = is_mem_state(state_nxt) && (state_nxt != state);

  assign retire = (state == ST_D || state == ST_E2 ||
                   state == ST_L2 || state == ST_S2) &&
                  (state_nxt == RESUME);

  seq_mem_wait #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_mem_wait (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .mem_ready(mem_ready),
    .done     (done),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir          <= '0;
      instr_count <= '0;
      fault       <= 1'b0;
    end else begin
      if (state == ST_F3) ir <= DATA;
      if (retire) instr_count <= instr_count + INSTR_CNT_W'(1);
      if (timeout) fault <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: state_nxt = RESUME;
      ST_F0:   state_nxt = ST_F1;
      ST_F1:   state_nxt = ST_F2;
      ST_F2: begin
        if (done)         state_nxt = ST_F3;
        else if (timeout) state_nxt = ST_HALT;
      end
      ST_F3:   state_nxt = ST_D;
      ST_D: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND,
          OP_OR, OP_MOV: state_nxt = ST_E0;
          OP_LD:         state_nxt = ST_L0;
          OP_ST:         state_nxt = ST_S0;
          OP_HLT:        state_nxt = ST_HALT;
          default:       state_nxt = RESUME;
        endcase
      end
      ST_E0:   state_nxt = (opcode == OP_MOV) ? ST_E2 : ST_E1;
      ST_E1:   state_nxt = ST_E2;
      ST_E2:   state_nxt = RESUME;
      ST_L0:   state_nxt = ST_L1;
      ST_L1: begin
        if (done)         state_nxt = ST_L2;
        else if (timeout) state_nxt = ST_HALT;
      end
      ST_L2:   state_nxt = RESUME;
      ST_S0:   state_nxt = ST_S1;
      ST_S1:   state_nxt = ST_S2;
      ST_S2: begin
        if (done)         state_nxt = RESUME;
        else if (timeout) state_nxt = ST_HALT;
      end
      ST_HALT: state_nxt = ST_HALT;
`ifdef SINGLE_STEP_EN
      ST_WAIT_STEP: state_nxt = step ? ST_F0 : ST_WAIT_STEP;
`else
      ST_WAIT_STEP: state_nxt = ST_F0;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stb = '0;
    unique case (state)
      ST_F0: begin
        stb.gpr_select = SEL_PC;
        stb.gpr_out    = 1'b1;
        stb.mar_in     = 1'b1;
        stb.alu_a_in   = 1'b1;
      end
      ST_F1: begin
        stb.alu_op     = ALU_INC;
        stb.alu_out    = 1'b1;
        stb.gpr_select = SEL_PC;
        stb.gpr_in     = 1'b1;
      end
      ST_F2, ST_L1: stb.mem_read = 1'b1;
      ST_F3:        stb.mdr_out  = 1'b1;
      ST_E0: begin
        stb.gpr_select = SEL_RS1;
        stb.gpr_out    = 1'b1;
        stb.alu_a_in   = 1'b1;
      end
      ST_E1: begin
        stb.gpr_select = SEL_RS2;
        stb.gpr_out    = 1'b1;
        stb.alu_b_in   = 1'b1;
      end
      ST_E2: begin
        stb.alu_out    = 1'b1;
        stb.gpr_select = SEL_RD1;
        stb.gpr_in     = 1'b1;
        // ADD..OR map onto ALU codes 000..011
        stb.alu_op     = (opcode == OP_MOV) ?
                         ALU_PASS : 3'(opcode - 4'd1);
      end
      ST_L0, ST_S0: begin
        stb.gpr_select = SEL_RS1;
        stb.gpr_out    = 1'b1;
        stb.mar_in     = 1'b1;
      end
      ST_L2: begin
        stb.mdr_out    = 1'b1;
        stb.gpr_select = SEL_RD1;
        stb.gpr_in     = 1'b1;
      end
      ST_S1: begin
        stb.gpr_select = SEL_RS2;
        stb.gpr_out    = 1'b1;
        stb.mdr_in     = 1'b1;
      end
      ST_S2:   stb.mem_write = 1'b1;
      default: stb = '0;
    endcase
  end

  assign GPR_in     = stb.gpr_in;
  assign GPR_out    = stb.gpr_out;
  assign GPR_select = stb.gpr_select;
  assign MAR_in     = stb.mar_in;
  assign MDR_in     = stb.mdr_in;
  assign MDR_out    = stb.mdr_out;
  assign MEM_read   = stb.mem_read;
  assign MEM_write  = stb.mem_write;
  assign ALU_A_in   = stb.alu_a_in;
  assign ALU_B_in   = stb.alu_b_in;
  assign ALU_out    = stb.alu_out;
  assign ALU_op     = stb.alu_op;
  assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer (default build).
// Expected cycles come from a per-instruction micro-op model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] DATA;
  logic        mem_ready;
  logic        GPR_in, GPR_out;
  logic [2:0]  GPR_select;
  logic [2:0]  Rd_1, Rd_2, Rs_1, Rs_2;
  logic        MAR_in, MDR_in, MDR_out;
  logic        MEM_read, MEM_write;
  logic        ALU_A_in, ALU_B_in, ALU_out;
  logic [2:0]  ALU_op;
  logic        halted, fault;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .DATA       (DATA),
    .mem_ready  (mem_ready),
    .GPR_in     (GPR_in),
    .GPR_out    (GPR_out),
    .GPR_select (GPR_select),
    .Rd_1       (Rd_1),
    .Rd_2       (Rd_2),
    .Rs_1       (Rs_1),
    .Rs_2       (Rs_2),
    .MAR_in     (MAR_in),
    .MDR_in     (MDR_in),
    .MDR_out    (MDR_out),
    .MEM_read   (MEM_read),
    .MEM_write  (MEM_write),
    .ALU_A_in   (ALU_A_in),
    .ALU_B_in   (ALU_B_in),
    .ALU_out    (ALU_out),
    .ALU_op     (ALU_op),
    .halted     (halted),
    .fault      (fault),
    .instr_count(instr_count)
  );

  // gin gout sel mar mdri mdro rd wr a b ao op
  localparam logic [15:0] U_NONE = 16'h0000;
  localparam logic [15:0] U_F0 =
    {2'b01, 3'b001, 3'b100, 2'b00, 3'b100, 3'b000};
  localparam logic [15:0] U_F1 =
    {2'b10, 3'b001, 3'b000, 2'b00, 3'b001, 3'b101};
  localparam logic [15:0] U_RD =
    {2'b00, 3'b000, 3'b000, 2'b10, 3'b000, 3'b000};
  localparam logic [15:0] U_MDRO =
    {2'b00, 3'b000, 3'b001, 2'b00, 3'b000, 3'b000};
  localparam logic [15:0] U_E0 =
    {2'b01, 3'b100, 3'b000, 2'b00, 3'b100, 3'b000};
  localparam logic [15:0] U_E1 =
    {2'b01, 3'b101, 3'b000, 2'b00, 3'b010, 3'b000};
  localparam logic [15:0] U_E2 =
    {2'b10, 3'b010, 3'b000, 2'b00, 3'b001, 3'b000};
  localparam logic [15:0] U_MAR_RS1 =
    {2'b01, 3'b100, 3'b100, 2'b00, 3'b000, 3'b000};
  localparam logic [15:0] U_L2 =
    {2'b10, 3'b010, 3'b001, 2'b00, 3'b000, 3'b000};
  localparam logic [15:0] U_S1 =
    {2'b01, 3'b101, 3'b010, 2'b00, 3'b000, 3'b000};
  localparam logic [15:0] U_WR =
    {2'b00, 3'b000, 3'b000, 2'b01, 3'b000, 3'b000};

  typedef struct {
    logic [15:0] stb;
    logic        mr;
    logic [15:0] data;
    logic [15:0] ir;
    logic [15:0] cnt;
    logic        halted;
    logic        fault;
  } cyc_t;

  cyc_t        exp_q[$];
  logic [15:0] m_ir, m_cnt;
  logic        m_halt, m_fault;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  task automatic push(input logic [15:0] stb, input logic mr,
                      input logic [15:0] data);
    cyc_t c;
    c.stb = stb; c.mr = mr; c.data = data;
    c.ir = m_ir; c.cnt = m_cnt;
    c.halted = m_halt; c.fault = m_fault;
    exp_q.push_back(c);
  endtask

  task automatic mem_step(input logic [15:0] stb, input int dly);
    for (int i = 0; i < dly; i++) push(stb, 1'b0, rnd16());
    push(stb, 1'b1, rnd16());
  endtask

  // one instruction: fetch, decode, then the opcode's execute steps
  task automatic add_instr(input logic [15:0] instr, input int dly);
    logic [3:0] op;
    op = instr[15:12];
    push(U_F0, rnd1(), rnd16());
    push(U_F1, rnd1(), rnd16());
    mem_step(U_RD, dly);
    push(U_MDRO, rnd1(), instr);
    m_ir = instr;
    push(U_NONE, rnd1(), rnd16());
    if (op >= 4'd1 && op <= 4'd4) begin
      push(U_E0, rnd1(), rnd16());
      push(U_E1, rnd1(), rnd16());
      push(U_E2 | {13'd0, 3'(op - 4'd1)}, rnd1(), rnd16());
      m_cnt++;
    end else if (op == 4'd5) begin
      push(U_E0, rnd1(), rnd16());
      push(U_E2 | 16'd4, rnd1(), rnd16());
      m_cnt++;
    end else if (op == 4'd6) begin
      push(U_MAR_RS1, rnd1(), rnd16());
      mem_step(U_RD, dly);
      push(U_L2, rnd1(), rnd16());
      m_cnt++;
    end else if (op == 4'd7) begin
      push(U_MAR_RS1, rnd1(), rnd16());
      push(U_S1, rnd1(), rnd16());
      mem_step(U_WR, dly);
      m_cnt++;
    end else if (op == 4'hF) begin
      m_halt = 1'b1;
      repeat (3) push(U_NONE, rnd1(), rnd16());
    end else begin
      m_cnt++;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ir = '0; m_cnt = '0; m_halt = 1'b0; m_fault = 1'b0;
  endtask

  task automatic start_program();
    reset = 1'b0; mem_ready = 1'b0; DATA = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    push(U_NONE, rnd1(), rnd16());
  endtask

  task automatic play(input string tag, input int limit);
    cyc_t        e;
    logic [15:0] obs;
    int          n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      e = exp_q.pop_front();
      mem_ready = e.mr;
      DATA = e.data;
      #1;
      obs = {GPR_in, GPR_out, GPR_select, MAR_in, MDR_in,
             MDR_out, MEM_read, MEM_write, ALU_A_in,
             ALU_B_in, ALU_out, ALU_op};
      n_cmp++;
      if (obs !== e.stb) begin
        n_err++;
        $display("FAIL %s strobes cyc %0d: got %h want %h",
                 tag, n, obs, e.stb);
      end
      n_cmp++;
      if ({Rd_1, Rs_1, Rs_2, Rd_2} !== e.ir[11:0]) begin
        n_err++;
        $display("FAIL %s fields cyc %0d: got %h want %h", tag, n,
                 {Rd_1, Rs_1, Rs_2, Rd_2}, e.ir[11:0]);
      end
      n_cmp++;
      if (instr_count !== e.cnt) begin
        n_err++;
        $display("FAIL %s instr_count cyc %0d: got %0d want %0d",
                 tag, n, instr_count, e.cnt);
      end
      n_cmp++;
      if ({halted, fault} !== {e.halted, e.fault}) begin
        n_err++;
        $display("FAIL %s halted/fault cyc %0d: got %b want %b",
                 tag, n, {halted, fault}, {e.halted, e.fault});
      end
      n_cmp++;
      if ((GPR_in && GPR_out) ||
          (int'(GPR_out) + int'(MDR_out) + int'(ALU_out) > 1)) begin
        n_err++;
        $display("FAIL %s bus_invariant cyc %0d: got %b want <=1 driver",
                 tag, n, {GPR_in, GPR_out, MDR_out, ALU_out});
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; DATA = rnd16(); mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({GPR_in, GPR_out, GPR_select, MAR_in, MDR_in, MDR_out,
         MEM_read, MEM_write, ALU_A_in, ALU_B_in, ALU_out,
         ALU_op} !== 16'h0) begin
      n_err++;
      $display("FAIL reset strobes: got nonzero want 0");
    end
    n_cmp++;
    if ({Rd_1, Rs_1, Rs_2, Rd_2, halted, fault} !== 14'h0 ||
        instr_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset state: got cnt %0d halt %b want 0",
               instr_count, halted);
    end
  endtask

  task automatic test_add();
    start_program();
    add_instr(16'h1298, 0);
    add_instr(16'hF000, 0);
    play("add", 1000);
    n_cmp++;
    if (instr_count !== 16'd1) begin
      n_err++;
      $display("FAIL add count: got %0d want 1", instr_count);
    end
  endtask

  task automatic test_mov();
    start_program();
    add_instr(16'h5280, 0);
    add_instr(16'h5280, 2);
    add_instr(16'hF000, 0);
    play("mov", 1000);
    n_cmp++;
    if (instr_count !== 16'd2) begin
      n_err++;
      $display("FAIL mov count: got %0d want 2", instr_count);
    end
  endtask

  task automatic test_store_load();
    start_program();
    add_instr(16'h7298, 3);
    add_instr(16'h6A51, 1);
    add_instr(16'hF000, 0);
    play("st_ld", 1000);
  endtask

  task automatic test_illegal();
    start_program();
    add_instr(16'h9ABC, 0);
    add_instr(16'hE123, 1);
    add_instr(16'h0FFF, 0);
    add_instr(16'hF000, 0);
    play("illegal", 1000);
    n_cmp++;
    if (instr_count !== 16'd3) begin
      n_err++;
      $display("FAIL illegal count: got %0d want 3", instr_count);
    end
  endtask

  task automatic test_wait_limit();
    start_program();
    add_instr(16'h6123, 14);
    add_instr(16'h7456, 14);
    add_instr(16'hF000, 0);
    play("wait_limit", 1000);
  endtask

  task automatic test_timeout();
    start_program();
    push(U_F0, rnd1(), rnd16());
    push(U_F1, rnd1(), rnd16());
    repeat (15) push(U_RD, 1'b0, rnd16());
    m_halt = 1'b1; m_fault = 1'b1;
    repeat (4) push(U_NONE, rnd1(), rnd16());
    play("timeout", 1000);
    n_cmp++;
    if (!(fault === 1'b1 && halted === 1'b1)) begin
      n_err++;
      $display("FAIL timeout flags: got %b%b want 11", fault, halted);
    end
  endtask

  task automatic test_halt_reset();
    start_program();
    add_instr(16'h1298, 0);
    add_instr(16'hF000, 0);
    play("halt", 1000);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (halted !== 1'b0 || instr_count !== 16'd0 ||
        {Rd_1, Rs_1, Rs_2, Rd_2} !== 12'h0) begin
      n_err++;
      $display("FAIL halt_reset: got halt %b cnt %0d want 0 0",
               halted, instr_count);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
    push(U_NONE, rnd1(), rnd16());
    add_instr(16'h2C5F, 0);
    add_instr(16'hF000, 0);
    play("after_halt", 1000);
  endtask

  task automatic test_mid_reset();
    start_program();
    add_instr(16'h0000, 0);
    add_instr(16'h4A5B, 2);
    play("mid", 10);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({GPR_in, GPR_out, MEM_read, MAR_in, ALU_out,
         MDR_out} !== 6'b0 || instr_count !== 16'd0 ||
        {Rd_1, Rs_1, Rs_2, Rd_2} !== 12'h0) begin
      n_err++;
      $display("FAIL mid_reset: got cnt %0d rd %0d want 0 0",
               instr_count, Rd_1);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
  endtask

  task automatic test_random();
    logic [15:0] instr;
    int          dly;
    start_program();
    for (int i = 0; i < 24; i++) begin
      instr = {4'($urandom_range(0, 14)), 12'($urandom)};
      dly = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
      add_instr(instr, dly);
    end
    add_instr(16'hF000, 0);
    play("random", 5000);
  endtask

  initial begin
    reset = 1'b0;
    DATA = '0;
    mem_ready = 1'b0;
    model_clear();
    test_reset();
    test_add();
    test_mov();
    test_store_load();
    test_illegal();
    test_wait_limit();
    test_timeout();
    test_halt_reset();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Control stage directly upstream of the general-purpose register file.
- Holds the instruction register (IR) and splits the instruction into the register-address fields Rd_1, Rd_2, Rs_1 and Rs_2.
- Steps a Moore state machine through fetch, decode and execute, driving GPR_in, GPR_out and GPR_select plus the MAR, MDR, memory and ALU strobes on the shared 16-bit bus.
- Program counter is GPR[7], selected by GPR_select=001.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles a memory strobe may wait for mem_ready before the sequencer faults.
- INSTR_CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  reset; asynchronous, active-low.
- DATA  in  16  bus value, sampled into IR in state F3.
- mem_ready  in  1  memory handshake complete.
- GPR_in  out  1  register file latches the bus.
- GPR_out  out  1  register file drives the bus.
- GPR_select  out  3  000 zero, 001 PC, 010 Rd_1, 011 Rd_2, 100 Rs_1, 101 Rs_2.
- Rd_1, Rd_2, Rs_1, Rs_2  out  3 each  IR fields.
- MAR_in  out  1  memory address register latches the bus.
- MDR_in  out  1  memory data register latches the bus.
- MDR_out  out  1  memory data register drives the bus.
- MEM_read  out  1  memory read request.
- MEM_write  out  1  memory write request.
- ALU_A_in  out  1  ALU operand A latches the bus.
- ALU_B_in  out  1  ALU operand B latches the bus.
- ALU_out  out  1  ALU drives the bus.
- ALU_op  out  3  ALU operation select.
- halted  out  1  HLT executed.
- fault  out  1  memory timeout.
- instr_count  out  INSTR_CNT_W  retired-instruction count.

Behaviour:
- Reset is asynchronous and active-low.
- Reset values: state=IDLE, IR=0, instr_count=0, halted=0, fault=0, wait counter=0, every strobe 0, ALU_op=000.
- IR format: [15:12] opcode, [11:9] Rd_1, [8:6] Rs_1, [5:3] Rs_2, [2:0] Rd_2.
- Field outputs are wired directly from IR.
- All strobes are Moore-decoded from the state register. A state not listed drives the strobe 0.
- Invariant: GPR_in and GPR_out are never both 1, and at most one bus driver (GPR_out, MDR_out, ALU_out) is active per cycle.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 MOV, 6 LD, 7 ST, F HLT. Codes 8-E are illegal and execute as NOP.
- ALU_op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 PASS, 101 INC.
- IDLE: no strobes -> F0.
- F0: GPR_select=001, GPR_out, MAR_in, ALU_A_in -> F1.
- F1: ALU_op=INC, ALU_out, GPR_select=001, GPR_in -> F2.
- F2: MEM_read, held until mem_ready=1, then -> F3.
- F3: MDR_out; IR<=DATA at the closing edge -> D.
- D: no strobes. Opcode 1-4 -> E0; 5 -> E0; 6 -> L0; 7 -> S0; F -> HALT; any other -> F0.
- E0: GPR_select=100, GPR_out, ALU_A_in. Opcode 5 -> E2; otherwise -> E1.
- E1: GPR_select=101, GPR_out, ALU_B_in -> E2.
- E2: ALU_out, GPR_select=010, GPR_in -> F0. ALU_op = opcode-1 for opcodes 1-4; PASS for opcode 5.
- L0: GPR_select=100, GPR_out, MAR_in -> L1.
- L1: MEM_read until mem_ready -> L2.
- L2: MDR_out, GPR_select=010, GPR_in -> F0.
- S0: GPR_select=100, GPR_out, MAR_in -> S1.
- S1: GPR_select=101, GPR_out, MDR_in -> S2.
- S2: MEM_write until mem_ready -> F0.
- HALT: halted=1, no strobes; exit only by reset.
- instr_count increments by 1 on each transition into F0 from E2, L2, S2 or D; it wraps at 2^INSTR_CNT_W.
- Wait counter clears on entry to F2, L1 or S2 and increments each cycle mem_ready=0.
  - If the count reaches MEM_WAIT_MAX with mem_ready still 0: go to HALT with fault=1 and halted=1.
  - mem_ready=1 on the same cycle the limit is reached counts as success.
- mem_ready is ignored outside F2, L1 and S2.
- Reset asserted mid-instruction returns to IDLE immediately; IR is not preserved.
- Cycles per instruction (mem_ready immediate): NOP/illegal 5, ALU 8, MOV 7, LD 8, ST 8.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- When defined, add input step (1 bit) and a state WAIT_STEP between every instruction-retiring transition and F0.
  - WAIT_STEP holds with no strobes until step=1 for one cycle, then goes to F0.
  - The first fetch after IDLE also waits for step.
- When undefined, the step port does not exist and all timing is as above.

Decomposition:
- Shared package seq_pkg holds:
  - state enum;
  - opcode constants OP_NOP..OP_HLT;
  - ALU_op constants;
  - GPR_select constants SEL_ZERO, SEL_PC, SEL_RD1, SEL_RD2, SEL_RS1, SEL_RS2.
- Sub-module seq_mem_wait: wait counter plus timeout compare, with inputs start, busy, mem_ready and outputs done, timeout. The counter is re-used by F2, L1 and S2.

Test Plan:
- Reset, mem_ready tied 1, DATA=0x1298 at F3 (ADD R1,R2,R3): observe GPR_select sequence 001,001,-,-,-,100,101,010; ALU_op=000 in E2; instr_count=1 after 8 cycles.
- DATA=0x5280 (MOV R1,R2): E1 skipped; E2 has ALU_op=100, GPR_in=1, GPR_select=010; 7 cycles total.
- DATA=0x7298 (ST): S1 drives GPR_select=101 with MDR_in; MEM_write held 3 cycles while mem_ready=0, released on the cycle mem_ready=1.
- mem_ready stuck 0 in F2: fault=1 and halted=1 after 15 wait cycles; all strobes 0 thereafter.
- DATA=0xF000 (HLT): halted=1; then reset pulse low for 1 cycle -> IDLE, halted=0, instr_count=0.
- Illegal opcode 0x9ABC: returns to F0 with no GPR_in after D; instr_count increments. Throughout every test, assert GPR_in&GPR_out never both 1.
